// File: rtl/mmu_xlate_pkg.sv
// Shared definitions for the MIPS32 address translator.
//   - mmu_exc_e : exception codes reported on rsp_exc
//   - TLB entry layout (LSB first): V1,D1,C1[2:0],PFN1[19:0],V0,D0,C0[2:0],PFN0[19:0],G,
//     ASID[ASID_W-1:0],VPN2[18:0]
//   - tlb_lo_t  : one page half of an entry {PFN,C,D,V}
package mmu_xlate_pkg;

   typedef enum logic [2:0] {
      MmuExcNone = 3'd0,
      MmuExcAdel = 3'd1,
      MmuExcAdes = 3'd2,
      MmuExcTlbl = 3'd3,
      MmuExcTlbs = 3'd4,
      MmuExcMod  = 3'd5
   } mmu_exc_e;

   localparam logic [2:0] CCA_UNCACHED = 3'd2;

   localparam int unsigned VPN2_W   = 19;
   localparam int unsigned PFN_W    = 20;
   localparam int unsigned LO_W     = 25;  // PFN + C + D + V
   localparam int unsigned LO1_OFF  = 0;
   localparam int unsigned LO0_OFF  = LO_W;
   localparam int unsigned G_OFF    = 2 * LO_W;
   localparam int unsigned ASID_OFF = G_OFF + 1;

   typedef struct packed {
      logic [PFN_W-1:0] pfn;
      logic [2:0]       c;
      logic             d;
      logic             v;
   } tlb_lo_t;

endpackage

// File: rtl/mmu_xlate_tlb_entry_match.sv
// Single TLB entry tag compare.
//   entry_vpn2/entry_asid/entry_g : stored tag of the entry
//   cmp_vpn2/cmp_asid             : tag being looked up
//   hit                           : VPN2 equal and (global or ASID equal)
module mmu_xlate_tlb_entry_match
   import mmu_xlate_pkg::*;
#(
   parameter int unsigned ASID_W = 8
) (
   input  logic [VPN2_W-1:0] entry_vpn2,
   input  logic [ASID_W-1:0] entry_asid,
   input  logic              entry_g,
   input  logic [VPN2_W-1:0] cmp_vpn2,
   input  logic [ASID_W-1:0] cmp_asid,
   output logic              hit
);

   assign hit = (entry_vpn2 == cmp_vpn2) && (entry_g || (entry_asid == cmp_asid));

endmodule

// File: rtl/mmu_xlate.sv
// Pipelined virtual->physical translator for one MIPS32 access port.
//   req_*    : request (valid/ready), vaddr, store flag, mode bits, ASID, kseg0 CCA
//   rsp_*    : registered result one cycle after accept, held while !rsp_ready
//   tlb_*    : TLB entry write port (takes effect at the clock edge)
//   probe_*  : TLBP probe, result one cycle later
module mmu_xlate
   import mmu_xlate_pkg::*;
#(
   parameter int unsigned TLB_ENTRIES = 16,
   parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES),
   parameter int unsigned ASID_W      = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [31:0]                        req_vaddr,
   input  logic                               req_store,
   input  logic                               user_mode,
   input  logic                               erl,
   input  logic [ASID_W-1:0]                  cur_asid,
   input  logic [2:0]                         k0_cca,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [31:0]                        rsp_paddr,
   output logic                               rsp_uncached,
   output logic [2:0]                         rsp_exc,
   output logic                               rsp_refill,
   input  logic                               tlb_we,
   input  logic [IDX_W-1:0]                   tlb_widx,
   input  logic [ASID_OFF+ASID_W+VPN2_W-1:0]  tlb_wdata,
   input  logic                               probe_valid,
   input  logic [VPN2_W-1:0]                  probe_vpn2,
   input  logic [ASID_W-1:0]                  probe_asid,
   output logic                               probe_done,
   output logic                               probe_miss,
   output logic [IDX_W-1:0]                   probe_idx
);

   localparam int unsigned ENTRY_W = ASID_OFF + ASID_W + VPN2_W;

   // TLB storage
   logic [ENTRY_W-1:0] tlb_q [TLB_ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            tlb_q[i] <= '0;
         end
      end else if (tlb_we) begin
         tlb_q[tlb_widx] <= tlb_wdata;
      end
   end

   // Per-entry compares for the lookup and probe paths
   logic [TLB_ENTRIES-1:0] lookup_hit;
   logic [TLB_ENTRIES-1:0] probe_hit;

   for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
      mmu_xlate_tlb_entry_match #(
         .ASID_W(ASID_W)
      ) u_lookup (
         .entry_vpn2 (tlb_q[i][ENTRY_W-1 -: VPN2_W]),
         .entry_asid (tlb_q[i][ASID_OFF +: ASID_W]),
         .entry_g    (tlb_q[i][G_OFF]),
         .cmp_vpn2   (req_vaddr[31:13]),
         .cmp_asid   (cur_asid),
         .hit        (lookup_hit[i])
      );

      mmu_xlate_tlb_entry_match #(
         .ASID_W(ASID_W)
      ) u_probe (
         .entry_vpn2 (tlb_q[i][ENTRY_W-1 -: VPN2_W]),
         .entry_asid (tlb_q[i][ASID_OFF +: ASID_W]),
         .entry_g    (tlb_q[i][G_OFF]),
         .cmp_vpn2   (probe_vpn2),
         .cmp_asid   (probe_asid),
         .hit        (probe_hit[i])
      );
   end

   // Lowest matching index wins on multiple hits
   logic             lookup_any;
   logic [IDX_W-1:0] lookup_idx;
   logic             probe_any;
   logic [IDX_W-1:0] probe_sel;

   always_comb begin
      lookup_any = 1'b0;
      lookup_idx = '0;
      probe_any  = 1'b0;
      probe_sel  = '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
         if (lookup_hit[i] && !lookup_any) begin
            lookup_any = 1'b1;
            lookup_idx = IDX_W'(i);
         end
         if (probe_hit[i] && !probe_any) begin
            probe_any = 1'b1;
            probe_sel = IDX_W'(i);
         end
      end
   end

   // Even/odd page half of the hit entry, chosen by va[12]
   logic [2*LO_W-1:0] sel_lo;
   tlb_lo_t           lo;

   assign sel_lo = tlb_q[lookup_idx][2*LO_W-1:0];
   assign lo     = req_vaddr[12] ? sel_lo[LO1_OFF +: LO_W] : sel_lo[LO0_OFF +: LO_W];

   // Combinational translation of the presented request
   logic [31:0] x_paddr;
   logic        x_uc;
   mmu_exc_e    x_exc;
   logic        x_refill;

   always_comb begin
      x_paddr  = '0;
      x_uc     = 1'b0;
      x_exc    = MmuExcNone;
      x_refill = 1'b0;
      if (user_mode && req_vaddr[31]) begin
         x_exc = req_store ? MmuExcAdes : MmuExcAdel;
      end else if (req_vaddr[31:29] == 3'b100) begin
         x_paddr = {3'b000, req_vaddr[28:0]};
         x_uc    = (k0_cca == CCA_UNCACHED);
      end else if (req_vaddr[31:29] == 3'b101) begin
         x_paddr = {3'b000, req_vaddr[28:0]};
         x_uc    = 1'b1;
      end else if (!req_vaddr[31] && erl) begin
         // Error level makes useg an uncached identity map
         x_paddr = req_vaddr;
         x_uc    = 1'b1;
      end else if (!lookup_any) begin
         x_exc    = req_store ? MmuExcTlbs : MmuExcTlbl;
         x_refill = 1'b1;
      end else if (!lo.v) begin
         x_exc = req_store ? MmuExcTlbs : MmuExcTlbl;
      end else if (req_store && !lo.d) begin
         x_exc = MmuExcMod;
      end else begin
         x_paddr = {lo.pfn, req_vaddr[11:0]};
         x_uc    = (lo.c == CCA_UNCACHED);
      end
   end

   // Response register
   logic        rsp_valid_q;
   logic [31:0] rsp_paddr_q;
   logic        rsp_uc_q;
   mmu_exc_e    rsp_exc_q;
   logic        rsp_refill_q;

   assign req_ready = !rsp_valid_q || rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_paddr_q  <= '0;
         rsp_uc_q     <= 1'b0;
         rsp_exc_q    <= MmuExcNone;
         rsp_refill_q <= 1'b0;
      end else if (req_ready) begin
         rsp_valid_q <= req_valid;
         if (req_valid) begin
            rsp_paddr_q  <= x_paddr;
            rsp_uc_q     <= x_uc;
            rsp_exc_q    <= x_exc;
            rsp_refill_q <= x_refill;
         end
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_paddr    = rsp_paddr_q;
   assign rsp_uncached = rsp_uc_q;
   assign rsp_exc      = rsp_exc_q;
   assign rsp_refill   = rsp_refill_q;

   // Probe result register
   logic             probe_done_q;
   logic             probe_miss_q;
   logic [IDX_W-1:0] probe_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         probe_done_q <= 1'b0;
         probe_miss_q <= 1'b0;
         probe_idx_q  <= '0;
      end else begin
         probe_done_q <= probe_valid;
         if (probe_valid) begin
            probe_miss_q <= !probe_any;
            probe_idx_q  <= probe_sel;
         end
      end
   end

   assign probe_done = probe_done_q;
   assign probe_miss = probe_miss_q;
   assign probe_idx  = probe_idx_q;

endmodule

// File: tb/tb_mmu_xlate.sv
module tb_mmu_xlate;
   import mmu_xlate_pkg::*;

   localparam int unsigned N  = 16;
   localparam int unsigned IW = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned EW = ASID_OFF + AW + VPN2_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_store, user_mode, erl;
   logic [31:0]   req_vaddr;
   logic [AW-1:0] cur_asid;
   logic [2:0]    k0_cca;
   logic          rsp_valid, rsp_ready, rsp_uncached, rsp_refill;
   logic [31:0]   rsp_paddr;
   logic [2:0]    rsp_exc;
   logic          tlb_we;
   logic [IW-1:0] tlb_widx;
   logic [EW-1:0] tlb_wdata;
   logic          probe_valid, probe_done, probe_miss;
   logic [18:0]   probe_vpn2;
   logic [AW-1:0] probe_asid;
   logic [IW-1:0] probe_idx;

   always #5 clk = ~clk;

   mmu_xlate #(.TLB_ENTRIES(N), .IDX_W(IW), .ASID_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
      .req_store(req_store), .user_mode(user_mode), .erl(erl), .cur_asid(cur_asid),
      .k0_cca(k0_cca), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
      .rsp_uncached(rsp_uncached), .rsp_exc(rsp_exc), .rsp_refill(rsp_refill),
      .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wdata(tlb_wdata),
      .probe_valid(probe_valid), .probe_vpn2(probe_vpn2), .probe_asid(probe_asid),
      .probe_done(probe_done), .probe_miss(probe_miss), .probe_idx(probe_idx)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [18:0] vpn2; logic [7:0] asid; logic g;
      logic [19:0] pfn0; logic [2:0] c0; logic d0; logic v0;
      logic [19:0] pfn1; logic [2:0] c1; logic d1; logic v1;
   } ent_t;

   typedef struct packed {
      logic [31:0] paddr; logic uc; logic [2:0] exc; logic refill;
   } rsp_t;

   ent_t m_tlb [N];

   function automatic logic [EW-1:0] pack(input ent_t e);
      return {e.vpn2, e.asid, e.g, e.pfn0, e.c0, e.d0, e.v0, e.pfn1, e.c1, e.d1, e.v1};
   endfunction

   function automatic int find(input logic [18:0] vpn2, input logic [7:0] asid);
      for (int i = 0; i < int'(N); i++)
         if (m_tlb[i].vpn2 == vpn2 && (m_tlb[i].g || m_tlb[i].asid == asid)) return i;
      return -1;
   endfunction

   function automatic rsp_t model(input logic [31:0] va, input logic st, input logic um,
                                  input logic er, input logic [7:0] asid,
                                  input logic [2:0] k0);
      rsp_t r;
      int   h;
      logic [19:0] pfn; logic [2:0] c; logic d, v;
      r = '0;
      if (um && va >= 32'h8000_0000) r.exc = st ? 3'd2 : 3'd1;
      else if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
         r.paddr = va - 32'h8000_0000; r.uc = (k0 == 3'd2);
      end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
         r.paddr = va - 32'hA000_0000; r.uc = 1'b1;
      end else if (va < 32'h8000_0000 && er) begin
         r.paddr = va; r.uc = 1'b1;
      end else begin
         h = find(19'(va / 8192), asid);
         if (h < 0) begin
            r.exc = st ? 3'd4 : 3'd3; r.refill = 1'b1;
         end else begin
            if ((va / 4096) % 2 == 1) begin
               pfn = m_tlb[h].pfn1; c = m_tlb[h].c1; d = m_tlb[h].d1; v = m_tlb[h].v1;
            end else begin
               pfn = m_tlb[h].pfn0; c = m_tlb[h].c0; d = m_tlb[h].d0; v = m_tlb[h].v0;
            end
            if (!v) r.exc = st ? 3'd4 : 3'd3;
            else if (st && !d) r.exc = 3'd5;
            else begin
               r.paddr = 32'(pfn) * 4096 + va % 4096; r.uc = (c == 3'd2);
            end
         end
      end
      return r;
   endfunction

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < int'(N); i++) m_tlb[i] = '0;
      tick();
      rst_n = 1'b1;
   endtask

   ent_t wr_ent;

   task automatic wr(input int idx, input ent_t e);
      tlb_we = 1'b1; tlb_widx = IW'(idx); wr_ent = e; tlb_wdata = pack(e);
      tick();
      tlb_we = 1'b0;
      m_tlb[idx] = e;
   endtask

   // Single request with constant expectations
   task automatic xl(input string name, input logic [31:0] va, input logic st,
                     input logic um, input logic er, input logic [7:0] asid,
                     input logic [2:0] k0, input logic [31:0] ep, input logic euc,
                     input logic [2:0] eexc, input logic eref);
      req_vaddr = va; req_store = st; user_mode = um; erl = er; cur_asid = asid;
      k0_cca = k0; req_valid = 1'b1; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk({name, " valid"}, 64'(rsp_valid), 64'd1);
      chk({name, " paddr"}, 64'(rsp_paddr), 64'(ep));
      chk({name, " uncached"}, 64'(rsp_uncached), 64'(euc));
      chk({name, " exc"}, 64'(rsp_exc), 64'(eexc));
      chk({name, " refill"}, 64'(rsp_refill), 64'(eref));
      tick();
   endtask

   // Cycle-level scoreboard shared by the backpressure and random phases
   rsp_t        exp_q [$];
   logic        stall_p = 1'b0;
   logic [63:0] held;
   logic        pend_p = 1'b0;
   int          pend_idx;
   int          n_recv;

   task automatic cycle(output bit acc);
      rsp_t        e;
      logic [63:0] now;
      #1;
      now = 64'({rsp_valid, rsp_paddr, rsp_uncached, rsp_exc, rsp_refill});
      if (stall_p) chk("stall hold", now, held);
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra rsp: got paddr 0x%0h, required no response", rsp_paddr);
         end else begin
            e = exp_q.pop_front();
            chk("rsp paddr", 64'(rsp_paddr), 64'(e.paddr));
            chk("rsp uncached", 64'(rsp_uncached), 64'(e.uc));
            chk("rsp exc", 64'(rsp_exc), 64'(e.exc));
            chk("rsp refill", 64'(rsp_refill), 64'(e.refill));
            n_recv++;
         end
      end
      chk("probe_done", 64'(probe_done), 64'(pend_p));
      if (pend_p) begin
         chk("probe_miss", 64'(probe_miss), 64'(pend_idx < 0));
         chk("probe_idx", 64'(probe_idx), pend_idx < 0 ? 64'd0 : 64'(pend_idx));
      end
      stall_p = rsp_valid && !rsp_ready;
      held = now;
      acc = req_valid && req_ready;
      // Lookup and probe see the TLB before this cycle's write
      if (acc) exp_q.push_back(model(req_vaddr, req_store, user_mode, erl, cur_asid, k0_cca));
      pend_p = probe_valid;
      if (probe_valid) pend_idx = find(probe_vpn2, probe_asid);
      if (tlb_we) m_tlb[tlb_widx] = wr_ent;
      tick();
   endtask

   function automatic logic [18:0] pick_vpn2();
      case ($urandom_range(0, 3))
         0: return 19'h00200;
         1: return 19'h00201;
         2: return 19'h60001;
         default: return 19'($urandom);
      endcase
   endfunction

   // ---------------- vectors ----------------
   typedef struct packed {
      logic [31:0] va; logic st; logic um; logic er; logic [7:0] asid; logic [2:0] k0;
      logic [31:0] ep; logic euc; logic [2:0] eexc; logic eref;
   } vec_t;

   vec_t vt [13];
   ent_t e3, e1, e7;
   bit   acc;
   int   sent;
   logic [31:0] bp_va [4];

   initial begin
      req_valid = 0; req_vaddr = 0; req_store = 0; user_mode = 0; erl = 0; cur_asid = 0;
      k0_cca = 3; rsp_ready = 1; tlb_we = 0; tlb_widx = 0; tlb_wdata = '0; wr_ent = '0;
      probe_valid = 0; probe_vpn2 = 0; probe_asid = 0;

      //                 va            st    um    er    asid  k0    paddr         uc  exc   rf
      vt[0]  = '{32'h8000_1234, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 32'h0000_1234, 1'b0, 3'd0, 1'b0};
      vt[1]  = '{32'h8000_1234, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2, 32'h0000_1234, 1'b1, 3'd0, 1'b0};
      vt[2]  = '{32'hA000_1234, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 32'h0000_1234, 1'b1, 3'd0, 1'b0};
      vt[3]  = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 8'd0, 3'd3, 32'h0, 1'b0, 3'd1, 1'b0};
      vt[4]  = '{32'hC000_0000, 1'b1, 1'b1, 1'b0, 8'd0, 3'd3, 32'h0, 1'b0, 3'd2, 1'b0};
      vt[5]  = '{32'h0040_0000, 1'b1, 1'b0, 1'b1, 8'd0, 3'd3, 32'h0040_0000, 1'b1, 3'd0, 1'b0};
      vt[6]  = '{32'h0040_0000, 1'b0, 1'b0, 1'b0, 8'd5, 3'd3, 32'h0, 1'b0, 3'd3, 1'b1};
      vt[7]  = '{32'hC000_2000, 1'b1, 1'b0, 1'b0, 8'd5, 3'd3, 32'h0, 1'b0, 3'd4, 1'b1};
      vt[8]  = '{32'h0040_0000, 1'b0, 1'b1, 1'b0, 8'd5, 3'd3, 32'h0, 1'b0, 3'd3, 1'b1};
      vt[9]  = '{32'hBFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 32'h1FFF_FFFF, 1'b1, 3'd0, 1'b0};
      vt[10] = '{32'h9FFF_FFFC, 1'b1, 1'b0, 1'b0, 8'd0, 3'd2, 32'h1FFF_FFFC, 1'b1, 3'd0, 1'b0};
      vt[11] = '{32'hC000_2000, 1'b0, 1'b0, 1'b1, 8'd5, 3'd3, 32'h0, 1'b0, 3'd3, 1'b1};
      vt[12] = '{32'h8000_0000, 1'b1, 1'b1, 1'b1, 8'd0, 3'd3, 32'h0, 1'b0, 3'd2, 1'b0};

      // Reset state
      rst_n = 1'b0;
      for (int i = 0; i < int'(N); i++) m_tlb[i] = '0;
      tick();
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset rsp_paddr", 64'(rsp_paddr), 64'd0);
      chk("reset rsp_exc", 64'(rsp_exc), 64'd0);
      chk("reset rsp_refill", 64'(rsp_refill), 64'd0);
      chk("reset rsp_uncached", 64'(rsp_uncached), 64'd0);
      chk("reset probe_done", 64'(probe_done), 64'd0);
      chk("reset probe_miss", 64'(probe_miss), 64'd0);
      chk("reset probe_idx", 64'(probe_idx), 64'd0);
      chk("reset req_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 13; i++)
         xl($sformatf("vec%0d", i), vt[i].va, vt[i].st, vt[i].um, vt[i].er, vt[i].asid,
            vt[i].k0, vt[i].ep, vt[i].euc, vt[i].eexc, vt[i].eref);

      // Refill, ASID, invalid and modified pages
      e3 = '{vpn2: 19'h00200, asid: 8'd5, g: 1'b0, pfn0: 20'h12345, c0: 3'd3, d0: 1'b0,
             v0: 1'b1, pfn1: 20'h54321, c1: 3'd2, d1: 1'b0, v1: 1'b0};
      wr(3, e3);
      xl("hit asid5", 32'h0040_0ABC, 0, 0, 0, 8'd5, 3, 32'h1234_5ABC, 0, 3'd0, 0);
      xl("miss asid6", 32'h0040_0ABC, 0, 0, 0, 8'd6, 3, 32'h0, 0, 3'd3, 1);
      xl("odd invalid", 32'h0040_1000, 0, 0, 0, 8'd5, 3, 32'h0, 0, 3'd3, 0);
      xl("odd inv store", 32'h0040_1000, 1, 0, 0, 8'd5, 3, 32'h0, 0, 3'd4, 0);
      xl("even mod", 32'h0040_0000, 1, 0, 0, 8'd5, 3, 32'h0, 0, 3'd5, 0);
      e3.g = 1'b1; e3.v1 = 1'b1;
      wr(3, e3);
      xl("global hit", 32'h0040_0ABC, 0, 0, 0, 8'd6, 3, 32'h1234_5ABC, 0, 3'd0, 0);
      xl("odd mod", 32'h0040_1000, 1, 0, 0, 8'd6, 3, 32'h0, 0, 3'd5, 0);
      xl("odd uc", 32'h0040_1010, 0, 0, 0, 8'd6, 3, 32'h5432_1010, 1, 3'd0, 0);
      e1 = '{vpn2: 19'h00200, asid: 8'd0, g: 1'b1, pfn0: 20'h00AAA, c0: 3'd2, d0: 1'b1,
             v0: 1'b1, pfn1: 20'h0, c1: 3'd0, d1: 1'b0, v1: 1'b0};
      wr(1, e1);
      xl("lowest idx", 32'h0040_0004, 1, 0, 0, 8'd6, 3, 32'h00AA_A004, 1, 3'd0, 0);
      xl("user mapped", 32'h0040_0ABC, 0, 1, 0, 8'd5, 3, 32'h00AA_AABC, 1, 3'd0, 0);

      // Backpressure: 4 kseg0 requests, consumer stalls 3 cycles mid-stream
      bp_va = '{32'h8000_0010, 32'h8000_0020, 32'h8000_0030, 32'h8000_0040};
      exp_q.delete(); stall_p = 0; pend_p = 0; n_recv = 0; sent = 0;
      user_mode = 0; erl = 0; req_store = 0; k0_cca = 3;
      for (int c = 0; c < 12; c++) begin
         rsp_ready = !(c >= 2 && c <= 4);
         req_valid = (sent < 4);
         req_vaddr = bp_va[sent % 4];
         cycle(acc);
         if (acc) sent++;
      end
      chk("bp results", 64'(n_recv), 64'd4);
      chk("bp leftover", 64'(exp_q.size()), 64'd0);
      req_valid = 0;

      // Probe racing a write to the same tag
      e7 = '{vpn2: 19'h12345, asid: 8'd9, g: 1'b0, pfn0: 20'h1, c0: 3'd3, d0: 1'b1,
             v0: 1'b1, pfn1: 20'h2, c1: 3'd3, d1: 1'b1, v1: 1'b1};
      probe_valid = 1; probe_vpn2 = 19'h12345; probe_asid = 8'd9;
      tlb_we = 1; tlb_widx = 4'd7; wr_ent = e7; tlb_wdata = pack(e7);
      tick();
      tlb_we = 0; m_tlb[7] = e7;
      chk("probe race done", 64'(probe_done), 64'd1);
      chk("probe race miss", 64'(probe_miss), 64'd1);
      chk("probe race idx", 64'(probe_idx), 64'd0);
      tick();
      probe_valid = 0;
      chk("reprobe done", 64'(probe_done), 64'd1);
      chk("reprobe miss", 64'(probe_miss), 64'd0);
      chk("reprobe idx", 64'(probe_idx), 64'd7);
      tick();
      chk("probe pulse end", 64'(probe_done), 64'd0);

      // Async reset drops an in-flight result and clears the TLB
      req_vaddr = 32'h8000_0010; req_valid = 1; rsp_ready = 0;
      tick();
      req_valid = 0;
      chk("pre-reset valid", 64'(rsp_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("async reset valid", 64'(rsp_valid), 64'd0);
      for (int i = 0; i < int'(N); i++) m_tlb[i] = '0;
      tick();
      rst_n = 1'b1; rsp_ready = 1;
      tick();
      chk("post-reset valid", 64'(rsp_valid), 64'd0);
      xl("tlb cleared", 32'h0040_0ABC, 0, 0, 0, 8'd5, 3, 32'h0, 0, 3'd3, 1);

      // Random traffic against the model
      do_reset();
      exp_q.delete(); stall_p = 0; pend_p = 0; n_recv = 0;
      for (int c = 0; c < 600; c++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         req_vaddr = ($urandom_range(0, 3) == 0) ? $urandom : {pick_vpn2(), 13'($urandom)};
         req_store = 1'($urandom);
         user_mode = ($urandom_range(0, 7) == 0);
         erl = ($urandom_range(0, 7) == 0);
         cur_asid = 8'($urandom_range(0, 3));
         k0_cca = 3'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         tlb_we = ($urandom_range(0, 4) == 0);
         wr_ent = '{vpn2: pick_vpn2(), asid: 8'($urandom_range(0, 3)), g: 1'($urandom),
                    pfn0: 20'($urandom), c0: 3'($urandom), d0: 1'($urandom),
                    v0: 1'($urandom), pfn1: 20'($urandom), c1: 3'($urandom),
                    d1: 1'($urandom), v1: 1'($urandom)};
         tlb_widx = IW'($urandom);
         tlb_wdata = pack(wr_ent);
         probe_valid = ($urandom_range(0, 9) < 3);
         probe_vpn2 = pick_vpn2();
         probe_asid = 8'($urandom_range(0, 3));
         cycle(acc);
      end
      req_valid = 0; tlb_we = 0; probe_valid = 0; rsp_ready = 1;
      repeat (3) cycle(acc);
      chk("random leftover", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
